// File: rtl/axi_lite_master_interface_pkg.sv
// rtl/axi_lite_master_interface_pkg.sv - shared encodings for the AXI-Lite master interface
package axi_lite_master_interface_pkg;

  // Read path FSM encoding
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  // Write path FSM encoding
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // AXI response code used as the idle/reset value of captured responses
  localparam logic [2:0] RESP_OKAY = 3'b000;

  // Protection attribute driven on AWPROT/ARPROT unless overridden
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master_wr_engine.sv
// rtl/axi_lite_master_wr_engine.sv - write path: AW/W issue, progress flags, B capture
module axi_lite_master_wr_engine
  import axi_lite_master_interface_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  WriteEnableIn,
  input  logic [ADDR_WIDTH-1:0] WriteAddrIn,
  input  logic [DATA_WIDTH-1:0] WriteDataIn,
  input  logic [STRB_WIDTH-1:0] WriteStrbIn,
  output logic                  WriteReadyOut,
  output logic                  WriteDoneOut,
  output logic [2:0]            WriteRespOut,
  output logic                  AWVALID,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWREADY,
  output logic                  WVALID,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WREADY,
  input  logic                  BVALID,
  input  logic [2:0]            BRESP,
  output logic                  BREADY
);

  wr_state_t             wr_state;
  logic                  awvalid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic                  wvalid_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  bready_q;
  logic                  done_q;
  logic [2:0]            bresp_q;

  // The address and data channels complete independently; these remember
  // which of the two has already been handshaken in the current write.
  logic                  aw_done;
  logic                  w_done;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  aw_complete;
  logic                  w_complete;

  assign aw_hs       = awvalid_q && AWREADY;
  assign w_hs        = wvalid_q && WREADY;
  assign aw_complete = aw_done || aw_hs;
  assign w_complete  = w_done || w_hs;

  // Write FSM: issue AW and W together, wait for both, then collect B
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_state  <= W_IDLE;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      done_q <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (WriteEnableIn) begin
            awaddr_q  <= WriteAddrIn;
            wdata_q   <= WriteDataIn;
            wstrb_q   <= WriteStrbIn;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            wr_state  <= W_SEND;
          end
        end
        W_SEND: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          // Both channels finished (possibly on this very edge): move on to B.
          if (aw_complete && w_complete) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            bready_q <= 1'b1;
            wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (BVALID) begin
            bready_q <= 1'b0;
            bresp_q  <= BRESP;
            done_q   <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          wr_state  <= W_IDLE;
        end
      endcase
    end
  end

  // Ready is a pure state decode so the core never sees an AXI-input path
  assign WriteReadyOut = (wr_state == W_IDLE);
  assign WriteDoneOut  = done_q;
  assign WriteRespOut  = bresp_q;
  assign AWVALID       = awvalid_q;
  assign AWADDR        = awaddr_q;
  assign WVALID        = wvalid_q;
  assign WDATA         = wdata_q;
  assign WSTRB         = wstrb_q;
  assign BREADY        = bready_q;

endmodule

// File: rtl/axi_lite_master_interface.sv
// rtl/axi_lite_master_interface.sv - core-side AXI-Lite master with independent read/write paths
module axi_lite_master_interface
  import axi_lite_master_interface_pkg::*;
#(
  parameter int         ADDR_WIDTH = 64,
  parameter int         DATA_WIDTH = 64,
  parameter int         STRB_WIDTH = 4,
  parameter logic [2:0] PROT_VALUE = PROT_DEFAULT
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // core read request side
  input  logic                  ReadEnableIn,
  input  logic [ADDR_WIDTH-1:0] ReadAddrIn,
  output logic                  ReadReadyOut,
  output logic                  ReadValidOut,
  output logic [DATA_WIDTH-1:0] ReadDataOut,
  output logic [2:0]            ReadRespOut,
  // core write request side
  input  logic                  WriteEnableIn,
  input  logic [ADDR_WIDTH-1:0] WriteAddrIn,
  input  logic [DATA_WIDTH-1:0] WriteDataIn,
  input  logic [STRB_WIDTH-1:0] WriteStrbIn,
  output logic                  WriteReadyOut,
  output logic                  WriteDoneOut,
  output logic [2:0]            WriteRespOut,
  // write address channel
  output logic                  AWVALID,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [2:0]            AWPROT,
  input  logic                  AWREADY,
  // write data channel
  output logic                  WVALID,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WREADY,
  // write response channel
  input  logic                  BVALID,
  input  logic [2:0]            BRESP,
  output logic                  BREADY,
  // read address channel
  output logic                  ARVALID,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [2:0]            ARPROT,
  input  logic                  ARREADY,
  // read data channel
  input  logic                  RVALID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [2:0]            RRESP,
  output logic                  RREADY
);

  rd_state_t             rd_state;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic                  rready_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [2:0]            rd_resp_q;

  // Read FSM: latch the request, present AR, then wait for R and report it
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rd_state   <= R_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      rready_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_resp_q  <= RESP_OKAY;
    end else begin
      rd_valid_q <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (ReadEnableIn) begin
            araddr_q  <= ReadAddrIn;
            arvalid_q <= 1'b1;
            rd_state  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            rd_state  <= R_DATA;
          end
        end
        R_DATA: begin
          // Response code is passed through as-is; errors are the core's business.
          if (RVALID) begin
            rready_q   <= 1'b0;
            rd_data_q  <= RDATA;
            rd_resp_q  <= RRESP;
            rd_valid_q <= 1'b1;
            rd_state   <= R_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          rd_state  <= R_IDLE;
        end
      endcase
    end
  end

  assign ReadReadyOut = (rd_state == R_IDLE);
  assign ReadValidOut = rd_valid_q;
  assign ReadDataOut  = rd_data_q;
  assign ReadRespOut  = rd_resp_q;
  assign ARVALID      = arvalid_q;
  assign ARADDR       = araddr_q;
  assign RREADY       = rready_q;
  assign ARPROT       = PROT_VALUE;
  assign AWPROT       = PROT_VALUE;

  axi_lite_master_wr_engine #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_wr_engine (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .WriteEnableIn (WriteEnableIn),
    .WriteAddrIn   (WriteAddrIn),
    .WriteDataIn   (WriteDataIn),
    .WriteStrbIn   (WriteStrbIn),
    .WriteReadyOut (WriteReadyOut),
    .WriteDoneOut  (WriteDoneOut),
    .WriteRespOut  (WriteRespOut),
    .AWVALID       (AWVALID),
    .AWADDR        (AWADDR),
    .AWREADY       (AWREADY),
    .WVALID        (WVALID),
    .WDATA         (WDATA),
    .WSTRB         (WSTRB),
    .WREADY        (WREADY),
    .BVALID        (BVALID),
    .BRESP         (BRESP),
    .BREADY        (BREADY)
  );

endmodule

// File: tb/tb_axi_lite_master_interface.sv
// tb/tb_axi_lite_master_interface.sv - self-checking bench for axi_lite_master_interface
module tb_axi_lite_master_interface;

  logic        ACLK;
  logic        ARESETn;
  logic        ReadEnableIn;
  logic [63:0] ReadAddrIn;
  logic        ReadReadyOut;
  logic        ReadValidOut;
  logic [63:0] ReadDataOut;
  logic [2:0]  ReadRespOut;
  logic        WriteEnableIn;
  logic [63:0] WriteAddrIn;
  logic [63:0] WriteDataIn;
  logic [3:0]  WriteStrbIn;
  logic        WriteReadyOut;
  logic        WriteDoneOut;
  logic [2:0]  WriteRespOut;
  logic        AWVALID;
  logic [63:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWREADY;
  logic        WVALID;
  logic [63:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WREADY;
  logic        BVALID;
  logic [2:0]  BRESP;
  logic        BREADY;
  logic        ARVALID;
  logic [63:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARREADY;
  logic        RVALID;
  logic [63:0] RDATA;
  logic [2:0]  RRESP;
  logic        RREADY;

  axi_lite_master_interface dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .ReadEnableIn  (ReadEnableIn),
    .ReadAddrIn    (ReadAddrIn),
    .ReadReadyOut  (ReadReadyOut),
    .ReadValidOut  (ReadValidOut),
    .ReadDataOut   (ReadDataOut),
    .ReadRespOut   (ReadRespOut),
    .WriteEnableIn (WriteEnableIn),
    .WriteAddrIn   (WriteAddrIn),
    .WriteDataIn   (WriteDataIn),
    .WriteStrbIn   (WriteStrbIn),
    .WriteReadyOut (WriteReadyOut),
    .WriteDoneOut  (WriteDoneOut),
    .WriteRespOut  (WriteRespOut),
    .AWVALID       (AWVALID),
    .AWADDR        (AWADDR),
    .AWPROT        (AWPROT),
    .AWREADY       (AWREADY),
    .WVALID        (WVALID),
    .WDATA         (WDATA),
    .WSTRB         (WSTRB),
    .WREADY        (WREADY),
    .BVALID        (BVALID),
    .BRESP         (BRESP),
    .BREADY        (BREADY),
    .ARVALID       (ARVALID),
    .ARADDR        (ARADDR),
    .ARPROT        (ARPROT),
    .ARREADY       (ARREADY),
    .RVALID        (RVALID),
    .RDATA         (RDATA),
    .RRESP         (RRESP),
    .RREADY        (RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // One transaction record: request, slave behaviour, expected completion cycles
  typedef struct {
    bit          rd;
    bit          wr;
    logic [63:0] raddr;
    logic [63:0] rdata;
    logic [2:0]  rresp;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  bresp;
    int          d_ar;
    int          d_r;
    int          d_aw;
    int          d_w;
    int          d_b;
    int          exp_rd_done;
    int          exp_wr_done;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // slave model configuration and progress
  int          d_ar, d_r, d_aw, d_w, d_b;
  logic [63:0] s_rdata;
  logic [2:0]  s_rresp, s_bresp;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit          r_pend, aw_got, w_got;
  bit          p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready;

  // reference state held across transactions
  logic [63:0] last_rdata;
  logic [2:0]  last_rresp, last_bresp;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rd, bit wr, logic [63:0] raddr, logic [63:0] rdata,
                              logic [2:0] rresp, logic [63:0] waddr, logic [63:0] wdata,
                              logic [3:0] wstrb, logic [2:0] bresp, int dar, int dr,
                              int daw, int dw, int db, int erd, int ewr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.raddr = raddr; v.rdata = rdata; v.rresp = rresp;
    v.waddr = waddr; v.wdata = wdata; v.wstrb = wstrb; v.bresp = bresp;
    v.d_ar = dar; v.d_r = dr; v.d_aw = daw; v.d_w = dw; v.d_b = db;
    v.exp_rd_done = erd; v.exp_wr_done = ewr;
    return v;
  endfunction

  task automatic slave_clear();
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; aw_got = 0; w_got = 0;
    p_arvalid = 0; p_rready = 0; p_awvalid = 0; p_wvalid = 0; p_bready = 0;
    ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
  endtask

  // Advance one clock; the slave reacts to what the master shows in the new cycle.
  task automatic step();
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    @(posedge ACLK);
    #1;
    cyc++;
    ar_hs = p_arvalid && ARREADY;
    r_hs  = RVALID && p_rready;
    aw_hs = p_awvalid && AWREADY;
    w_hs  = p_wvalid && WREADY;
    b_hs  = BVALID && p_bready;
    if (ar_hs) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; end
    if (r_hs) r_pend = 0;
    if (aw_hs) begin aw_got = 1; aw_cnt = 0; end
    if (w_hs) begin w_got = 1; w_cnt = 0; end
    if (b_hs) begin aw_got = 0; w_got = 0; b_cnt = 0; end
    ARREADY = ARVALID && (ar_cnt >= d_ar);
    if (ARVALID && !ARREADY) ar_cnt++;
    RVALID = r_pend && (r_cnt >= d_r);
    if (r_pend && !RVALID) r_cnt++;
    AWREADY = AWVALID && (aw_cnt >= d_aw);
    if (AWVALID && !AWREADY) aw_cnt++;
    WREADY = WVALID && (w_cnt >= d_w);
    if (WVALID && !WREADY) w_cnt++;
    BVALID = aw_got && w_got && (b_cnt >= d_b);
    if (aw_got && w_got && !BVALID) b_cnt++;
    RDATA = s_rdata;
    RRESP = s_rresp;
    BRESP = s_bresp;
    p_arvalid = ARVALID; p_rready = RREADY; p_awvalid = AWVALID;
    p_wvalid = WVALID; p_bready = BREADY;
  endtask

  // Issue one vector and check every output cycle by cycle against
  // the channel windows implied by the slave delays.
  task automatic run(input vec_t v, input bit busy);
    int rd_done, wr_done, t_end, m;
    rd_done = v.rd ? v.exp_rd_done : 0;
    wr_done = v.wr ? v.exp_wr_done : 0;
    t_end   = (rd_done > wr_done) ? rd_done : wr_done;
    m       = (v.d_aw > v.d_w) ? v.d_aw : v.d_w;
    d_ar = v.d_ar; d_r = v.d_r; d_aw = v.d_aw; d_w = v.d_w; d_b = v.d_b;
    s_rdata = v.rdata; s_rresp = v.rresp; s_bresp = v.bresp;
    ReadEnableIn  = v.rd;
    ReadAddrIn    = v.raddr;
    WriteEnableIn = v.wr;
    WriteAddrIn   = v.waddr;
    WriteDataIn   = v.wdata;
    WriteStrbIn   = v.wstrb;
    for (int t = 1; t <= t_end; t++) begin
      step();
      WriteEnableIn = 1'b0;
      ReadEnableIn  = busy && (t < rd_done);
      if (busy) ReadAddrIn = 64'h10;
      chk1("ARVALID", ARVALID, v.rd && (t <= 1 + v.d_ar));
      if (ARVALID) chk64("ARADDR", ARADDR, v.raddr);
      chk1("RREADY", RREADY, v.rd && (t >= 2 + v.d_ar) && (t <= rd_done - 1));
      chk1("ReadValidOut", ReadValidOut, v.rd && (t == rd_done));
      chk1("ReadReadyOut", ReadReadyOut, !(v.rd && (t <= rd_done - 1)));
      chk64("ReadDataOut", ReadDataOut, (v.rd && t >= rd_done) ? v.rdata : last_rdata);
      chk64("ReadRespOut", 64'(ReadRespOut),
            64'((v.rd && t >= rd_done) ? v.rresp : last_rresp));
      chk1("AWVALID", AWVALID, v.wr && (t <= 1 + v.d_aw));
      if (AWVALID) chk64("AWADDR", AWADDR, v.waddr);
      chk1("WVALID", WVALID, v.wr && (t <= 1 + v.d_w));
      if (WVALID) begin
        chk64("WDATA", WDATA, v.wdata);
        chk64("WSTRB", 64'(WSTRB), 64'(v.wstrb));
      end
      chk1("BREADY", BREADY, v.wr && (t >= 2 + m) && (t <= wr_done - 1));
      chk1("WriteDoneOut", WriteDoneOut, v.wr && (t == wr_done));
      chk1("WriteReadyOut", WriteReadyOut, !(v.wr && (t <= wr_done - 1)));
      chk64("WriteRespOut", 64'(WriteRespOut),
            64'((v.wr && t >= wr_done) ? v.bresp : last_bresp));
      chk64("PROT", 64'({ARPROT, AWPROT}), 64'(0));
    end
    if (v.rd) begin last_rdata = v.rdata; last_rresp = v.rresp; end
    if (v.wr) last_bresp = v.bresp;
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_ReadReadyOut"}, ReadReadyOut, 1'b1);
    chk1({tag, "_WriteReadyOut"}, WriteReadyOut, 1'b1);
    chk1({tag, "_ARVALID"}, ARVALID, 1'b0);
    chk1({tag, "_RREADY"}, RREADY, 1'b0);
    chk1({tag, "_AWVALID"}, AWVALID, 1'b0);
    chk1({tag, "_WVALID"}, WVALID, 1'b0);
    chk1({tag, "_BREADY"}, BREADY, 1'b0);
    chk1({tag, "_ReadValidOut"}, ReadValidOut, 1'b0);
    chk1({tag, "_WriteDoneOut"}, WriteDoneOut, 1'b0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = mk(1, 0, 64'h8000_0000, 64'h1122_3344_5566_7788, 3'b000,
                64'h0, 64'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 3, 0);
    tbl[1] = mk(0, 1, 64'h0, 64'h0, 3'b000,
                64'h4000_0100, 64'hDEAD_BEEF, 4'hF, 3'b111, 0, 0, 0, 3, 0, 0, 6);
    tbl[2] = mk(1, 1, 64'h8000_0040, 64'hCAFE_F00D_0000_0001, 3'b001,
                64'h4000_0200, 64'h0123_4567_89AB_CDEF, 4'h5, 3'b000, 1, 1, 0, 2, 0, 5, 5);
    tbl[3] = mk(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011,
                64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'hA, 3'b010, 0, 4, 2, 1, 1, 7, 6);
    tbl[4] = mk(1, 0, 64'h8000_1000, 64'hA5A5_A5A5_5A5A_5A5A, 3'b000,
                64'h0, 64'h0, 4'h0, 3'b000, 0, 10, 0, 0, 0, 13, 0);
    tbl[5] = mk(1, 0, 64'h8000_2008, 64'h0000_0000_0000_0042, 3'b010,
                64'h0, 64'h0, 4'h0, 3'b000, 3, 0, 0, 0, 0, 6, 0);
    tbl[6] = mk(0, 1, 64'h0, 64'h0, 3'b000,
                64'h4000_0300, 64'h7777_0000_8888_1111, 4'h3, 3'b010, 4, 0, 4, 0, 2, 0, 9);

    d_ar = 0; d_r = 0; d_aw = 0; d_w = 0; d_b = 0;
    s_rdata = '0; s_rresp = '0; s_bresp = '0;
    slave_clear();
    RDATA = '0; RRESP = '0; BRESP = '0;
    ARESETn = 1'b0;
    ReadEnableIn = 1'b0; ReadAddrIn = '0;
    WriteEnableIn = 1'b0; WriteAddrIn = '0; WriteDataIn = '0; WriteStrbIn = '0;
    last_rdata = '0; last_rresp = '0; last_bresp = '0;

    // reset state
    repeat (3) step();
    chk_idle("rst");
    chk64("rst_ReadDataOut", ReadDataOut, 64'h0);
    chk64("rst_ARADDR", ARADDR, 64'h0);
    chk64("rst_AWADDR", AWADDR, 64'h0);
    chk64("rst_WDATA", WDATA, 64'h0);
    chk64("rst_resps", 64'({ReadRespOut, WriteRespOut, WSTRB}), 64'(0));
    ARESETn = 1'b1;
    step();

    // directed vectors
    for (int i = 0; i < 7; i++) run(tbl[i], 1'b0);

    // request while busy is ignored, then reissued
    run(mk(1, 0, 64'h8000_3000, 64'h0BAD_F00D_1234_5678, 3'b000,
           64'h0, 64'h0, 4'h0, 3'b000, 0, 3, 0, 0, 0, 6, 0), 1'b1);
    run(mk(1, 0, 64'h10, 64'h0000_1010_2020_3030, 3'b000,
           64'h0, 64'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 3, 0), 1'b0);

    // reset with read in R_DATA and write in W_SEND
    d_ar = 0; d_r = 50; d_aw = 50; d_w = 50; d_b = 0;
    ReadEnableIn = 1'b1; ReadAddrIn = 64'hA000;
    WriteEnableIn = 1'b1; WriteAddrIn = 64'hB000; WriteDataIn = 64'h5; WriteStrbIn = 4'h1;
    step();
    ReadEnableIn = 1'b0; WriteEnableIn = 1'b0;
    step();
    chk1("pre_rst_RREADY", RREADY, 1'b1);
    chk1("pre_rst_AWVALID", AWVALID, 1'b1);
    chk1("pre_rst_WVALID", WVALID, 1'b1);
    ARESETn = 1'b0;
    step();
    chk_idle("midrst");
    chk64("midrst_ReadDataOut", ReadDataOut, 64'h0);
    ARESETn = 1'b1;
    slave_clear();
    last_rdata = '0; last_rresp = '0; last_bresp = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle("postrst");
    end

    // randomized traffic against the window model
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.rd = 1'($urandom_range(0, 1));
      v.wr = v.rd ? 1'($urandom_range(0, 1)) : 1'b1;
      v.raddr = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom};
      v.rresp = 3'($urandom_range(0, 7));
      v.waddr = {$urandom, $urandom};
      v.wdata = {$urandom, $urandom};
      v.wstrb = 4'($urandom_range(0, 15));
      v.bresp = 3'($urandom_range(0, 7));
      v.d_ar = $urandom_range(0, 5);
      v.d_r  = $urandom_range(0, 5);
      v.d_aw = $urandom_range(0, 5);
      v.d_w  = $urandom_range(0, 5);
      v.d_b  = $urandom_range(0, 5);
      v.exp_rd_done = 3 + v.d_ar + v.d_r;
      v.exp_wr_done = 3 + ((v.d_aw > v.d_w) ? v.d_aw : v.d_w) + v.d_b;
      run(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
